// File: rtl/axi_pkg.sv
// Shared AXI3 encodings, address-channel payload type and round-robin helpers
// used by the master arbiter and its write-order queue.
package axi_pkg;

   localparam int ID_W = 4;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10,
      BURST_RSVD  = 2'b11
   } axi_burst_e;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } axi_resp_e;

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      axi_burst_e  burst;
   } axi_ax_t;

   // Returns {found, index}: first requester at or after ptr, wrapping modulo n.
   function automatic logic [4:0] rr_pick(input logic [15:0] req, input logic [3:0] ptr,
                                          input logic [4:0] n);
      logic [4:0] res;
      logic [4:0] idx;
      res = 5'd0;
      for (int i = 0; i < 16; i++) begin
         idx = {1'b0, ptr} + 5'(i);
         if (idx >= n) idx = idx - n;
         else          idx = idx;
         if ((5'(i) < n) && !res[4] && req[idx[3:0]]) res = {1'b1, idx[3:0]};
         else                                          res = res;
      end
      return res;
   endfunction

   function automatic logic [3:0] rr_next(input logic [3:0] idx, input logic [4:0] n);
      if (({1'b0, idx} + 5'd1) >= n) return 4'd0;
      else                           return idx + 4'd1;
   endfunction

endpackage

// File: rtl/axi_id_fifo.sv
// Write-order queue: remembers which master owns each accepted AW so that
// W beats are forwarded in address order.
module axi_id_fifo
   import axi_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic            aclk,
   input  logic            aresetn,
   input  logic            push,
   input  logic [ID_W-1:0] din,
   input  logic            pop,
   output logic [ID_W-1:0] dout,
   output logic            full,
   output logic            empty
);

   localparam int PW = $clog2(DEPTH);

   logic [ID_W-1:0] mem_r [DEPTH];
   logic [PW-1:0]   wr_ptr_r;
   logic [PW-1:0]   rd_ptr_r;
   logic [PW:0]     count_r;
   logic            push_ok_s;
   logic            pop_ok_s;

   assign full      = (count_r == (PW+1)'(DEPTH));
   assign empty     = (count_r == (PW+1)'(0));
   assign push_ok_s = push && !full;
   assign pop_ok_s  = pop && !empty;
   assign dout      = mem_r[rd_ptr_r];

   // Storage array.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      end else if (push_ok_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_ok_s) wr_ptr_r <= wr_ptr_r + PW'(1);
         if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + (PW+1)'(1);
            2'b01:   count_r <= count_r - (PW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/axi_master_arbiter.sv
// N-to-1 AXI3 arbiter: round-robin AR/AW slots with a one-deep register each,
// W ordered by a write-order queue, R/B steered back by transaction id.
module axi_master_arbiter
   import axi_pkg::*;
#(
   parameter int NUM_MASTERS    = 3,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int WQ_DEPTH       = 4
) (
   input  logic                                    aclk,
   input  logic                                    aresetn,
   input  logic [NUM_MASTERS-1:0]                  s_arvalid,
   output logic [NUM_MASTERS-1:0]                  s_arready,
   input  logic [NUM_MASTERS*32-1:0]               s_araddr,
   input  logic [NUM_MASTERS*8-1:0]                s_arlen,
   input  logic [NUM_MASTERS*3-1:0]                s_arsize,
   input  logic [NUM_MASTERS*2-1:0]                s_arburst,
   output logic [NUM_MASTERS-1:0]                  s_rvalid,
   input  logic [NUM_MASTERS-1:0]                  s_rready,
   output logic [AXI_DATA_WIDTH-1:0]               s_rdata,
   output logic [1:0]                              s_rresp,
   output logic                                    s_rlast,
   input  logic [NUM_MASTERS-1:0]                  s_awvalid,
   output logic [NUM_MASTERS-1:0]                  s_awready,
   input  logic [NUM_MASTERS*32-1:0]               s_awaddr,
   input  logic [NUM_MASTERS*8-1:0]                s_awlen,
   input  logic [NUM_MASTERS*3-1:0]                s_awsize,
   input  logic [NUM_MASTERS*2-1:0]                s_awburst,
   input  logic [NUM_MASTERS-1:0]                  s_wvalid,
   output logic [NUM_MASTERS-1:0]                  s_wready,
   input  logic [NUM_MASTERS*AXI_DATA_WIDTH-1:0]   s_wdata,
   input  logic [NUM_MASTERS*AXI_DATA_WIDTH/8-1:0] s_wstrb,
   input  logic [NUM_MASTERS-1:0]                  s_wlast,
   output logic [NUM_MASTERS-1:0]                  s_bvalid,
   input  logic [NUM_MASTERS-1:0]                  s_bready,
   output logic [1:0]                              s_bresp,
   output logic [ID_W-1:0]                         m_arid,
   output logic [31:0]                             m_araddr,
   output logic [7:0]                              m_arlen,
   output logic [2:0]                              m_arsize,
   output logic [1:0]                              m_arburst,
   output logic [1:0]                              m_arlock,
   output logic [3:0]                              m_arcache,
   output logic [2:0]                              m_arprot,
   output logic                                    m_arvalid,
   input  logic                                    m_arready,
   input  logic [ID_W-1:0]                         m_rid,
   input  logic [AXI_DATA_WIDTH-1:0]               m_rdata,
   input  logic [1:0]                              m_rresp,
   input  logic                                    m_rlast,
   input  logic                                    m_rvalid,
   output logic                                    m_rready,
   output logic [ID_W-1:0]                         m_awid,
   output logic [31:0]                             m_awaddr,
   output logic [7:0]                              m_awlen,
   output logic [2:0]                              m_awsize,
   output logic [1:0]                              m_awburst,
   output logic [1:0]                              m_awlock,
   output logic [3:0]                              m_awcache,
   output logic [2:0]                              m_awprot,
   output logic                                    m_awvalid,
   input  logic                                    m_awready,
   output logic [ID_W-1:0]                         m_wid,
   output logic [AXI_DATA_WIDTH-1:0]               m_wdata,
   output logic [AXI_DATA_WIDTH/8-1:0]             m_wstrb,
   output logic                                    m_wlast,
   output logic                                    m_wvalid,
   input  logic                                    m_wready,
   input  logic [ID_W-1:0]                         m_bid,
   input  logic [1:0]                              m_bresp,
   input  logic                                    m_bvalid,
   output logic                                    m_bready
);

   localparam logic [4:0] NM = 5'(NUM_MASTERS);
   localparam int         SW = AXI_DATA_WIDTH / 8;

   logic [4:0]      ar_pick_s, aw_pick_s;
   logic            ar_acc_s, aw_acc_s;
   axi_ax_t         ar_sel_s, aw_sel_s, ar_pl_r, aw_pl_r;
   logic            ar_vld_r, aw_vld_r;
   logic [ID_W-1:0] ar_id_r, aw_id_r;
   logic [3:0]      rr_ar_r, rr_aw_r;
   logic            wq_full_s, wq_empty_s, wq_pop_s;
   logic [ID_W-1:0] wq_head_s;

   assign ar_pick_s = rr_pick(16'(s_arvalid), rr_ar_r, NM);
   assign aw_pick_s = rr_pick(16'(s_awvalid), rr_aw_r, NM);
   // A slot accepts only when it is empty or drains this very cycle.
   assign ar_acc_s  = aresetn && (!ar_vld_r || m_arready) && ar_pick_s[4];
   assign aw_acc_s  = aresetn && (!aw_vld_r || m_awready) && !wq_full_s && aw_pick_s[4];

   // Grant decode and winner payload selection for both address channels.
   always_comb begin
      s_arready = '0;
      s_awready = '0;
      ar_sel_s  = '0;
      aw_sel_s  = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         s_arready[i] = ar_acc_s && (ar_pick_s[3:0] == 4'(i));
         s_awready[i] = aw_acc_s && (aw_pick_s[3:0] == 4'(i));
         if (ar_pick_s[3:0] == 4'(i))
            ar_sel_s = '{addr: s_araddr[i*32 +: 32], len: s_arlen[i*8 +: 8], size: s_arsize[i*3 +: 3],
                         burst: axi_burst_e'(s_arburst[i*2 +: 2])};
         else
            ar_sel_s = ar_sel_s;
         if (aw_pick_s[3:0] == 4'(i))
            aw_sel_s = '{addr: s_awaddr[i*32 +: 32], len: s_awlen[i*8 +: 8], size: s_awsize[i*3 +: 3],
                         burst: axi_burst_e'(s_awburst[i*2 +: 2])};
         else
            aw_sel_s = aw_sel_s;
      end
   end

   // AR slot and pointer.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         ar_vld_r <= 1'b0;
         ar_id_r  <= '0;
         ar_pl_r  <= '0;
         rr_ar_r  <= 4'd0;
      end else if (ar_acc_s) begin
         ar_vld_r <= 1'b1;
         ar_id_r  <= ar_pick_s[3:0];
         ar_pl_r  <= ar_sel_s;
         rr_ar_r  <= rr_next(ar_pick_s[3:0], NM);
      end else if (m_arready) begin
         ar_vld_r <= 1'b0;
      end
   end

   // AW slot and pointer.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         aw_vld_r <= 1'b0;
         aw_id_r  <= '0;
         aw_pl_r  <= '0;
         rr_aw_r  <= 4'd0;
      end else if (aw_acc_s) begin
         aw_vld_r <= 1'b1;
         aw_id_r  <= aw_pick_s[3:0];
         aw_pl_r  <= aw_sel_s;
         rr_aw_r  <= rr_next(aw_pick_s[3:0], NM);
      end else if (m_awready) begin
         aw_vld_r <= 1'b0;
      end
   end

   assign m_arvalid = ar_vld_r;
   assign m_arid    = ar_id_r;
   assign m_araddr  = ar_pl_r.addr;
   assign m_arlen   = ar_pl_r.len;
   assign m_arsize  = ar_pl_r.size;
   assign m_arburst = ar_pl_r.burst;
   assign m_arlock  = 2'b00;
   assign m_arcache = 4'b0000;
   assign m_arprot  = 3'b000;
   assign m_awvalid = aw_vld_r;
   assign m_awid    = aw_id_r;
   assign m_awaddr  = aw_pl_r.addr;
   assign m_awlen   = aw_pl_r.len;
   assign m_awsize  = aw_pl_r.size;
   assign m_awburst = aw_pl_r.burst;
   assign m_awlock  = 2'b00;
   assign m_awcache = 4'b0000;
   assign m_awprot  = 3'b000;

   axi_id_fifo #(.DEPTH(WQ_DEPTH)) u_wq (
      .aclk    (aclk),
      .aresetn (aresetn),
      .push    (aw_acc_s),
      .din     (aw_pick_s[3:0]),
      .pop     (wq_pop_s),
      .dout    (wq_head_s),
      .full    (wq_full_s),
      .empty   (wq_empty_s)
   );

   assign m_wid    = wq_head_s;
   assign wq_pop_s = m_wvalid && m_wready && m_wlast;

   // W steering from the master at the head of the write-order queue.
   always_comb begin
      m_wvalid = 1'b0;
      m_wdata  = '0;
      m_wstrb  = '0;
      m_wlast  = 1'b0;
      s_wready = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (!wq_empty_s && (wq_head_s == 4'(i))) begin
            m_wvalid    = s_wvalid[i];
            m_wdata     = s_wdata[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
            m_wstrb     = s_wstrb[i*SW +: SW];
            m_wlast     = s_wlast[i];
            s_wready[i] = m_wready;
         end else begin
            s_wready[i] = 1'b0;
         end
      end
   end

   assign s_rdata = m_rdata;
   assign s_rresp = m_rresp;
   assign s_rlast = m_rlast;
   assign s_bresp = m_bresp;

   // R/B steering by id; ids with no master behind them are sunk.
   always_comb begin
      s_rvalid = '0;
      s_bvalid = '0;
      m_rready = 1'b1;
      m_bready = 1'b1;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (m_rid == 4'(i)) begin
            s_rvalid[i] = m_rvalid;
            m_rready    = s_rready[i];
         end else begin
            s_rvalid[i] = 1'b0;
         end
         if (m_bid == 4'(i)) begin
            s_bvalid[i] = m_bvalid;
            m_bready    = s_bready[i];
         end else begin
            s_bvalid[i] = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Directed and randomized checks of axi_master_arbiter against a queue-based
// transaction model of the arbitration, ordering and routing rules.
module tb_axi_master_arbiter;

   localparam int N  = 3;
   localparam int DW = 32;
   localparam int WQ = 4;

   logic aclk = 1'b0;
   logic aresetn;
   always #5 aclk = ~aclk;

   logic [N-1:0]        s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
   logic [N-1:0]        s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
   logic [N*32-1:0]     s_araddr, s_awaddr;
   logic [N*8-1:0]      s_arlen, s_awlen;
   logic [N*3-1:0]      s_arsize, s_awsize;
   logic [N*2-1:0]      s_arburst, s_awburst;
   logic [DW-1:0]       s_rdata, m_rdata, m_wdata;
   logic [1:0]          s_rresp, s_bresp, m_rresp, m_bresp;
   logic                s_rlast, m_rlast, m_rvalid, m_rready, m_wlast, m_wvalid, m_wready;
   logic [N*DW-1:0]     s_wdata;
   logic [N*DW/8-1:0]   s_wstrb;
   logic [DW/8-1:0]     m_wstrb;
   logic [3:0]          m_arid, m_awid, m_rid, m_wid, m_bid;
   logic [31:0]         m_araddr, m_awaddr;
   logic [7:0]          m_arlen, m_awlen;
   logic [2:0]          m_arsize, m_awsize, m_arprot, m_awprot;
   logic [1:0]          m_arburst, m_awburst, m_arlock, m_awlock;
   logic [3:0]          m_arcache, m_awcache;
   logic                m_arvalid, m_arready, m_awvalid, m_awready, m_bvalid, m_bready;

   axi_master_arbiter #(.NUM_MASTERS(N), .AXI_DATA_WIDTH(DW), .WQ_DEPTH(WQ)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
      .s_arsize(s_arsize), .s_arburst(s_arburst),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
      .s_awsize(s_awsize), .s_awburst(s_awburst),
      .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
      .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
      .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
      .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot), .m_arvalid(m_arvalid),
      .m_arready(m_arready),
      .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
      .m_rready(m_rready),
      .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
      .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot), .m_awvalid(m_awvalid),
      .m_awready(m_awready),
      .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
      .m_wready(m_wready),
      .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
   );

   int errors = 0;
   int checks = 0;

   // Reference model state: pointers, the two address slots, and the order queue.
   int          ptr_ar, ptr_aw, arid_m, awid_m;
   bit          arv, awv;
   logic [44:0] arpl_m, awpl_m;
   int          wq[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic int pick(input logic [N-1:0] req, input int ptr);
      for (int k = 0; k < N; k++)
         if (req[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   function automatic logic [N-1:0] oh(input int w);
      logic [N-1:0] v;
      v = '0;
      if (w >= 0 && w < N) v[w] = 1'b1;
      return v;
   endfunction

   task automatic rnd_payload();
      for (int i = 0; i < N; i++) begin
         s_araddr[i*32 +: 32] = $urandom;
         s_awaddr[i*32 +: 32] = $urandom;
         s_arlen[i*8 +: 8]    = 8'($urandom);
         s_awlen[i*8 +: 8]    = 8'($urandom);
         s_arsize[i*3 +: 3]   = 3'($urandom);
         s_awsize[i*3 +: 3]   = 3'($urandom);
         s_arburst[i*2 +: 2]  = 2'($urandom);
         s_awburst[i*2 +: 2]  = 2'($urandom);
         s_wdata[i*DW +: DW]  = $urandom;
         s_wstrb[i*4 +: 4]    = 4'($urandom);
      end
   endtask

   task automatic idle();
      s_arvalid = '0; s_awvalid = '0; s_wvalid = '0; s_wlast = '0;
      s_rready = '0; s_bready = '0;
      m_arready = 1'b1; m_awready = 1'b1; m_wready = 1'b0;
      m_rvalid = 1'b0; m_rid = 4'd0; m_rdata = '0; m_rresp = 2'b00; m_rlast = 1'b0;
      m_bvalid = 1'b0; m_bid = 4'd0; m_bresp = 2'b00;
   endtask

   task automatic rnd_all();
      rnd_payload();
      s_arvalid = N'($urandom); s_awvalid = N'($urandom);
      s_wvalid = N'($urandom); s_wlast = N'($urandom);
      s_rready = N'($urandom); s_bready = N'($urandom);
      m_arready = ($urandom_range(0, 3) != 0);
      m_awready = ($urandom_range(0, 3) != 0);
      m_wready  = ($urandom_range(0, 2) != 0);
      m_rvalid = 1'($urandom); m_rid = 4'($urandom_range(0, 5));
      m_rdata = $urandom; m_rresp = 2'($urandom); m_rlast = 1'($urandom);
      m_bvalid = 1'($urandom); m_bid = 4'($urandom_range(0, 5)); m_bresp = 2'($urandom);
   endtask

   // Compare every output against the model at negedge, then advance the model across the edge.
   task automatic step();
      int war, waw, h, r;
      logic [N-1:0] ewr, erv;
      logic err;
      bit pop;
      @(negedge aclk);
      war = -1;
      waw = -1;
      if (aresetn && (!arv || m_arready)) war = pick(s_arvalid, ptr_ar);
      if (aresetn && (!awv || m_awready) && wq.size() < WQ) waw = pick(s_awvalid, ptr_aw);
      chk("s_arready", s_arready, oh(war));
      chk("m_arvalid", m_arvalid, arv);
      chk("m_arid", m_arid, arid_m);
      chk("m_ar_payload", {m_araddr, m_arlen, m_arsize, m_arburst}, arpl_m);
      chk("s_awready", s_awready, oh(waw));
      chk("m_awvalid", m_awvalid, awv);
      chk("m_awid", m_awid, awid_m);
      chk("m_aw_payload", {m_awaddr, m_awlen, m_awsize, m_awburst}, awpl_m);
      pop = 1'b0;
      ewr = '0;
      if (wq.size() > 0) begin
         h = wq[0];
         chk("m_wvalid", m_wvalid, s_wvalid[h]);
         chk("m_wid", m_wid, h);
         chk("m_w_payload", {m_wdata, m_wstrb, m_wlast}, {s_wdata[h*DW +: DW], s_wstrb[h*4 +: 4], s_wlast[h]});
         ewr = oh(h) & {N{m_wready}};
         pop = s_wvalid[h] && m_wready && s_wlast[h];
      end else begin
         chk("m_wvalid_empty", m_wvalid, 1'b0);
      end
      chk("s_wready", s_wready, ewr);
      r = int'(m_rid);
      if (r < N) begin erv = m_rvalid ? oh(r) : '0; err = s_rready[r]; end
      else       begin erv = '0; err = 1'b1; end
      chk("s_rvalid", s_rvalid, erv);
      chk("m_rready", m_rready, err);
      chk("s_r_bcast", {s_rdata, s_rresp, s_rlast}, {m_rdata, m_rresp, m_rlast});
      r = int'(m_bid);
      if (r < N) begin erv = m_bvalid ? oh(r) : '0; err = s_bready[r]; end
      else       begin erv = '0; err = 1'b1; end
      chk("s_bvalid", s_bvalid, erv);
      chk("m_bready", m_bready, err);
      chk("s_bresp", s_bresp, m_bresp);
      chk("m_const", {m_arlock, m_arcache, m_arprot, m_awlock, m_awcache, m_awprot}, 64'd0);
      if (!aresetn) begin
         arv = 1'b0; awv = 1'b0; arid_m = 0; awid_m = 0; arpl_m = '0; awpl_m = '0;
         ptr_ar = 0; ptr_aw = 0; wq.delete();
      end else begin
         if (war >= 0) begin
            arv = 1'b1; arid_m = war; ptr_ar = (war + 1) % N;
            arpl_m = {s_araddr[war*32 +: 32], s_arlen[war*8 +: 8], s_arsize[war*3 +: 3], s_arburst[war*2 +: 2]};
         end else if (m_arready) begin
            arv = 1'b0;
         end
         if (waw >= 0) begin
            awv = 1'b1; awid_m = waw; ptr_aw = (waw + 1) % N;
            awpl_m = {s_awaddr[waw*32 +: 32], s_awlen[waw*8 +: 8], s_awsize[waw*3 +: 3], s_awburst[waw*2 +: 2]};
            wq.push_back(waw);
         end else if (m_awready) begin
            awv = 1'b0;
         end
         if (pop) void'(wq.pop_front());
      end
      @(posedge aclk);
      #1;
   endtask

   int          exp_aw [4] = '{2, 0, 1, 2};
   logic [3:0]  sav_id;
   logic [31:0] sav_addr;

   initial begin
      ptr_ar = 0; ptr_aw = 0; arid_m = 0; awid_m = 0; arv = 1'b0; awv = 1'b0;
      arpl_m = '0; awpl_m = '0;
      idle();
      rnd_payload();
      aresetn = 1'b0;
      s_arvalid = '1;
      s_awvalid = '1;
      @(posedge aclk);
      #1;
      step();
      step();
      chk("rst_s_arready", s_arready, 3'b000);
      chk("rst_s_awready", s_awready, 3'b000);
      chk("rst_m_arvalid", m_arvalid, 1'b0);
      chk("rst_m_awvalid", m_awvalid, 1'b0);
      chk("rst_m_arid", m_arid, 4'd0);
      chk("rst_m_araddr", m_araddr, 32'd0);
      chk("rst_m_awaddr", m_awaddr, 32'd0);

      // All three masters requesting: grants rotate 0,1,2,0.
      aresetn = 1'b1;
      s_awvalid = '0;
      s_arvalid = 3'b111;
      for (int k = 0; k < 4; k++) begin
         rnd_payload();
         step();
         chk("t030_grant", m_arid, 4'(k % 3));
      end

      // Downstream stall: slot holds, no further grants.
      m_arready = 1'b0;
      sav_id = m_arid;
      sav_addr = m_araddr;
      for (int k = 0; k < 5; k++) begin
         rnd_payload();
         step();
         chk("t031_addr", m_araddr, sav_addr);
         chk("t031_id", m_arid, sav_id);
         chk("t031_noready", s_arready, 3'b000);
      end
      m_arready = 1'b1;
      s_arvalid = '0;
      step();

      // Single read from master 0 and its four R beats.
      s_arvalid = 3'b001;
      s_araddr[31:0] = 32'h1C00_0000;
      s_arlen[7:0] = 8'd3;
      #1;
      chk("t029_grant", s_arready, 3'b001);
      step();
      s_arvalid = '0;
      chk("t029_arvalid", m_arvalid, 1'b1);
      chk("t029_arid", m_arid, 4'd0);
      chk("t029_araddr", m_araddr, 32'h1C00_0000);
      chk("t029_arlen", m_arlen, 8'd3);
      for (int b = 0; b < 4; b++) begin
         m_rvalid = 1'b1; m_rid = 4'd0; m_rlast = (b == 3); m_rdata = $urandom;
         s_rready = N'($urandom);
         #1;
         chk("t029_rvalid", s_rvalid, 3'b001);
         chk("t029_rready", m_rready, s_rready[0]);
         step();
      end
      m_rid = 4'd7;
      s_rready = '0;
      #1;
      chk("t016_rvalid_oor", s_rvalid, 3'b000);
      chk("t016_rready_oor", m_rready, 1'b1);
      step();
      m_rvalid = 1'b0;

      // Writes from master 2 then master 1; W follows address order.
      s_awvalid = 3'b100;
      s_awlen[23:16] = 8'd1;
      #1;
      chk("t032_aw2", s_awready, 3'b100);
      step();
      s_awvalid = 3'b010;
      s_awlen[15:8] = 8'd1;
      #1;
      chk("t032_aw1", s_awready, 3'b010);
      step();
      s_awvalid = '0;
      m_wready = 1'b1;
      s_wvalid = 3'b111;
      for (int b = 0; b < 4; b++) begin
         s_wlast = (b % 2 == 1) ? 3'b111 : 3'b000;
         rnd_payload();
         #1;
         chk("t032_wid", m_wid, (b < 2) ? 4'd2 : 4'd1);
         chk("t032_wready", s_wready, (b < 2) ? 3'b100 : 3'b010);
         step();
      end
      chk("t019_wvalid_empty", m_wvalid, 1'b0);
      chk("t019_wready_empty", s_wready, 3'b000);
      s_wvalid = '0;
      m_bvalid = 1'b1; m_bid = 4'd1; s_bready = 3'b010;
      #1;
      chk("t032_bvalid", s_bvalid, 3'b010);
      chk("t032_bready", m_bready, 1'b1);
      step();
      m_bvalid = 1'b0;

      // Fill the order queue with W stalled; fifth AW waits for a wlast handshake.
      m_wready = 1'b0;
      s_wvalid = 3'b111;
      s_wlast = 3'b111;
      s_awvalid = 3'b111;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("t033_accept", m_awid, 4'(exp_aw[k]));
      end
      for (int k = 0; k < 2; k++) begin
         chk("t033_full", s_awready, 3'b000);
         step();
      end
      m_wready = 1'b1;
      #1;
      chk("t033_pop_cycle", s_awready, 3'b000);
      step();
      m_wready = 1'b0;
      #1;
      chk("t033_after_pop", s_awready, 3'b001);
      step();

      // Reset in the middle of a W burst.
      s_awvalid = '0;
      s_arvalid = 3'b111;
      m_arready = 1'b0;
      step();
      s_wlast = '0;
      m_wready = 1'b1;
      step();
      chk("t034_pre_arvalid", m_arvalid, 1'b1);
      aresetn = 1'b0;
      step();
      chk("t034_arvalid", m_arvalid, 1'b0);
      chk("t034_awvalid", m_awvalid, 1'b0);
      chk("t034_wvalid", m_wvalid, 1'b0);
      aresetn = 1'b1;
      s_awvalid = 3'b111;
      m_arready = 1'b1;
      #1;
      chk("t034_ar_ptr0", s_arready, 3'b001);
      chk("t034_aw_ptr0", s_awready, 3'b001);
      step();

      // Randomized traffic with occasional resets.
      for (int c = 0; c < 400; c++) begin
         rnd_all();
         aresetn = ($urandom_range(0, 63) != 0);
         step();
      end
      aresetn = 1'b1;
      idle();
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axi_master_arbiter.md
AXI_MASTER_ARBITER -- requirements
Module: axi_master_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 3, number of upstream AXI3 masters (legal range 1..16).
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 32, data width of all W/R channels.
REQ-003 SHALL have parameter WQ_DEPTH, default 4, depth of write-order queue (power of 2, >=2).
REQ-004 SHALL have port aclk  in  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port aresetn  in  1  synchronous, active-low reset.
REQ-006 SHALL have ports s_arvalid/s_arready  in/out  NUM_MASTERS  per-master AR handshake.
REQ-007 SHALL have ports s_araddr, s_arlen, s_arsize, s_arburst  in  NUM_MASTERS x{32,8,3,2}  packed per-master AR payload.
REQ-008 SHALL have ports s_rvalid/s_rready  out/in  NUM_MASTERS  per-master R handshake; s_rdata, s_rresp, s_rlast  out  shared broadcast of m_r*.
REQ-009 SHALL have ports s_awvalid/s_awready, s_awaddr, s_awlen, s_awsize, s_awburst  as AR, for write address.
REQ-010 SHALL have ports s_wvalid/s_wready, s_wdata, s_wstrb, s_wlast  in/out  NUM_MASTERS x{1,1,AXI_DATA_WIDTH,AXI_DATA_WIDTH/8,1}.
REQ-011 SHALL have ports s_bvalid/s_bready  out/in  NUM_MASTERS; s_bresp  out  2  broadcast.
REQ-012 SHALL have full AXI3 master port m_ar*, m_r*, m_aw*, m_w* (incl. m_wid), m_b*, id width 4, toward the memory system.

Function
REQ-013 SHALL arbitrate AR round-robin: priority starts at rr_ar pointer, winner w gets s_arready[w]=1 for one cycle, payload latched into AR register, rr_ar <= w+1 mod NUM_MASTERS.
REQ-014 SHALL drive m_arvalid from AR register 1 cycle after s_arready; m_arid = w; register reloads only when empty or m_arready handshake occurs that cycle.
REQ-015 SHALL hold m_ar*/m_aw* payload and id stable while valid && !ready.
REQ-016 SHALL route R by rid: s_rvalid[rid]=m_rvalid, m_rready=s_rready[rid]; rid>=NUM_MASTERS -> m_rready=1, beat discarded.
REQ-017 SHALL arbitrate AW identically (own pointer rr_aw), additionally accepting only when write-order queue not full; accepted index pushed into queue same cycle.
REQ-018 SHALL drive W from queue head h: m_wvalid=s_wvalid[h], s_wready[h]=m_wready, m_wid=h; all other s_wready=0; pop on m_wvalid&&m_wready&&m_wlast.
REQ-019 SHALL, with queue empty, hold m_wvalid=0 and all s_wready=0.
REQ-020 SHALL block AW when queue full even if pop occurs same cycle; push and pop same cycle when not full/empty keep count constant.
REQ-021 SHALL route B by bid like R (REQ-016).
REQ-022 SHALL drive m_arlock/m_awlock=0, m_arcache/m_awcache=0, m_arprot/m_awprot=0 constant.
REQ-023 SHALL add no latency on R, W, B paths (combinational routing).

Reset
REQ-024 SHALL, on aresetn=0 at a clock edge, clear m_arvalid, m_awvalid, all s_arready/s_awready, rr_ar=rr_aw=0, queue empty; mid-burst transfers abandoned.
REQ-025 SHALL drive m_arid/m_awid=0 and address registers 0 after reset.

Structure
REQ-026 SHALL place AXI burst/resp encodings, id width 4 and AR/AW payload struct in shared package axi_pkg.
REQ-027 SHALL implement the write-order queue as sub-module axi_id_fifo (WQ_DEPTH x 4 bits, full/empty flags).
REQ-028 SHALL implement round-robin selection as one reusable function shared by AR and AW.

Verification
REQ-029 SHALL test: master0 AR 0x1C00_0000 len=3 -> m_arid=0 next cycle, 4 R beats rid=0 reach only s_rvalid[0].
REQ-030 SHALL test: masters 0,1,2 arvalid together, m_arready=1 -> grants 0,1,2 on consecutive accepts, then 0.
REQ-031 SHALL test: m_arready=0 for 5 cycles -> m_araddr/m_arid stable, no further s_arready.
REQ-032 SHALL test: AW from master2 then master1, len=1 each -> m_wid=2 for 2 beats, then 1; bid=1 -> s_bvalid[1] only.
REQ-033 SHALL test: 4 AWs accepted with W stalled -> 5th s_awready=0 until first wlast handshake, then accepted.
REQ-034 SHALL test: aresetn=0 during W burst -> m_arvalid=m_awvalid=m_wvalid=0 next cycle, pointers 0.
